// File: rtl/hazard_pkg.sv
// Shared constants and types for the scoreboarded hazard controller.
//   PC_SEQ            : pc_jump encoding for sequential fetch
//   FWD_RF..FWD_WB    : per-source forwarding select encodings
//   idx_t             : register index type for the default 32-register file
package hazard_pkg;

  localparam logic [2:0] PC_SEQ  = 3'b001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned RW_DFLT = 5;
  typedef logic [RW_DFLT-1:0] idx_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard for long-latency producers.
//   clk, rst_n        : clock, async active-low reset
//   set_en, set_idx   : mark set_idx as having a pending long-latency write
//   clr_en, clr_idx   : write-back completed for clr_idx
//   pend              : flat pending vector; bit 0 is always 0
module hazard_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [RW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [RW-1:0]   clr_idx,
  output logic [NREG-1:0] pend
);

  logic [NREG-1:1] pend_q;

  // Set beats clear on the same index: the new producer is younger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (set_en && set_idx == RW'(r)) begin
          pend_q[r] <= 1'b1;
        end else if (clr_en && clr_idx == RW'(r)) begin
          pend_q[r] <= 1'b0;
        end
      end
    end
  end

  assign pend = {pend_q, 1'b0};

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Scoreboarded pipeline hazard controller beside the ID stage.
//   clk, rst_n              : clock, async active-low reset
//   pc_jump                 : PC select; anything but PC_SEQ is a redirect
//   id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_long : ID instruction
//   exe_rd/exe_fwd_ok, mem_rd/mem_fwd_ok, wb_rd/wb_wen     : downstream stages
//   stall, flush, id_issue, fwd_sel : same-cycle control (forced 0 in reset)
//   stall_cycles            : saturating count of stalled cycles
//   hazard_err              : sticky stall-timeout error
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned RW      = 5,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          pc_jump,
  input  logic                id_valid,
  input  logic [NSRC*RW-1:0]  id_rs,
  input  logic [NSRC-1:0]     id_rs_used,
  input  logic [RW-1:0]       id_rd,
  input  logic                id_rd_wen,
  input  logic                id_long,
  input  logic [RW-1:0]       exe_rd,
  input  logic [RW-1:0]       mem_rd,
  input  logic [RW-1:0]       wb_rd,
  input  logic                exe_fwd_ok,
  input  logic                mem_fwd_ok,
  input  logic                wb_wen,
  output logic                stall,
  output logic                flush,
  output logic                id_issue,
  output logic [NSRC*2-1:0]   fwd_sel,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic                hazard_err
);

  localparam int unsigned RUN_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [NREG-1:0]    pend;
  logic [NSRC-1:0]    blocked;
  logic [NSRC*2-1:0]  fwd_int;
  logic               waw;
  logic               redirect;
  logic               stall_int;
  logic               issue_int;
  logic               set_en;
  logic [RW-1:0]      rs;
  logic [RUN_W-1:0]   run_cnt;

  hazard_scoreboard #(
    .NREG (NREG),
    .RW   (RW)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en),
    .set_idx (id_rd),
    .clr_en  (wb_wen),
    .clr_idx (wb_rd),
    .pend    (pend)
  );

  // Per-source blocking and forwarding; a WB bypass releases the block.
  always_comb begin
    blocked = '0;
    fwd_int = '0;
    rs      = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      rs = id_rs[i*RW +: RW];
      if (id_rs_used[i] && rs != '0) begin
        blocked[i] = pend[rs] && !(wb_wen && wb_rd == rs);
        if (exe_fwd_ok && exe_rd == rs) begin
          fwd_int[i*2 +: 2] = FWD_EXE;
        end else if (mem_fwd_ok && mem_rd == rs) begin
          fwd_int[i*2 +: 2] = FWD_MEM;
        end else if (wb_wen && wb_rd == rs) begin
          fwd_int[i*2 +: 2] = FWD_WB;
        end else begin
          fwd_int[i*2 +: 2] = FWD_RF;
        end
      end
    end
  end

  // Redirect wins over stall: the stalled instruction is being killed anyway.
  always_comb begin
    waw       = id_rd_wen && (id_rd != '0) && pend[id_rd] &&
                !(wb_wen && wb_rd == id_rd);
    redirect  = (pc_jump != PC_SEQ);
    stall_int = id_valid && !redirect && ((|blocked) || waw);
    issue_int = id_valid && !stall_int && !redirect;
    set_en    = issue_int && id_rd_wen && id_long && (id_rd != '0);
  end

  assign stall    = rst_n & stall_int;
  assign flush    = rst_n & redirect;
  assign id_issue = rst_n & issue_int;
  assign fwd_sel  = rst_n ? fwd_int : '0;

  // Saturating stall counter, consecutive-stall run counter and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      run_cnt      <= '0;
      hazard_err   <= 1'b0;
    end else begin
      if (stall_int) begin
        if (stall_cycles != '1) begin
          stall_cycles <= stall_cycles + CNT_W'(1);
        end
        if (run_cnt != '1) begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
        if ((TIMEOUT != 0) && (run_cnt == RUN_W'(TO_LAST))) begin
          hazard_err <= 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed self-checking bench for hazard_ctrl_sb (NSRC=3, CNT_W=4, TIMEOUT=8).
module tb_hazard_ctrl_sb;
  import hazard_pkg::*;

  localparam int unsigned NREG = 32, RW = 5, NSRC = 3, CNT_W = 4, TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         pc_jump;
  logic               id_valid;
  logic [NSRC*RW-1:0] id_rs;
  logic [NSRC-1:0]    id_rs_used;
  idx_t               id_rd;
  logic               id_rd_wen, id_long;
  idx_t               exe_rd, mem_rd, wb_rd;
  logic               exe_fwd_ok, mem_fwd_ok, wb_wen;
  logic               stall, flush, id_issue;
  logic [NSRC*2-1:0]  fwd_sel;
  logic [CNT_W-1:0]   stall_cycles;
  logic               hazard_err;

  int errors = 0;
  int checks = 0;
  logic [NSRC*RW-1:0] rs_tmp;

  hazard_ctrl_sb #(
    .NREG(NREG), .RW(RW), .NSRC(NSRC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_jump(pc_jump), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
    .id_rd_wen(id_rd_wen), .id_long(id_long), .exe_rd(exe_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .exe_fwd_ok(exe_fwd_ok),
    .mem_fwd_ok(mem_fwd_ok), .wb_wen(wb_wen), .stall(stall), .flush(flush),
    .id_issue(id_issue), .fwd_sel(fwd_sel), .stall_cycles(stall_cycles),
    .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pc_jump = PC_SEQ; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_rd_wen = 1'b0; id_long = 1'b0;
    exe_rd = '0; mem_rd = '0; wb_rd = '0;
    exe_fwd_ok = 1'b0; mem_fwd_ok = 1'b0; wb_wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset forces combinational outputs low even with hazardous inputs.
    rst_n = 1'b0; idle();
    id_valid = 1'b1; pc_jump = 3'b010; id_rs_used = '1; id_rs = {5'd0, 5'd0, 5'd5};
    exe_rd = 5'd5; exe_fwd_ok = 1'b1;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_issue", 32'(id_issue), 0);
    chk("rst_fwd", 32'(fwd_sel), 0);
    chk("rst_cnt", 32'(stall_cycles), 0);
    chk("rst_err", 32'(hazard_err), 0);
    @(negedge clk); rst_n = 1'b1; idle();

    // Load to x5, then a reader of x5 stalls until WB bypass.
    @(negedge clk); id_valid = 1'b1; id_rd = 5'd5; id_rd_wen = 1'b1; id_long = 1'b1;
    #1 chk("load_issue", 32'(id_issue), 1);
    chk("load_nostall", 32'(stall), 0);
    @(negedge clk); id_rd = 5'd6; id_long = 1'b0; id_rs = {5'd0, 5'd0, 5'd5}; id_rs_used = 3'b001;
    #1 chk("pend5_set", 32'(dut.pend[5]), 1);
    chk("raw_stall", 32'(stall), 1);
    chk("raw_noissue", 32'(id_issue), 0);
    repeat (2) begin
      @(negedge clk); #1 chk("raw_stall_hold", 32'(stall), 1);
    end
    @(negedge clk); wb_wen = 1'b1; wb_rd = 5'd5;
    #1 chk("wb_release", 32'(stall), 0);
    chk("wb_fwd", 32'(fwd_sel), 32'h03);
    chk("wb_issue", 32'(id_issue), 1);
    chk("cnt_3", 32'(stall_cycles), 3);
    @(negedge clk); idle();
    #1 chk("pend5_clr", 32'(dut.pend[5]), 0);

    // Forwarding priority on source 1; used source 2 is x0 and stays 00.
    @(negedge clk); id_valid = 1'b1; id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b110;
    exe_rd = 5'd7; exe_fwd_ok = 1'b1; mem_rd = 5'd7; mem_fwd_ok = 1'b1;
    #1 chk("fwd_exe", 32'(fwd_sel), 32'h04);
    chk("fwd_nostall", 32'(stall), 0);
    exe_fwd_ok = 1'b0;
    #1 chk("fwd_mem", 32'(fwd_sel), 32'h08);
    mem_fwd_ok = 1'b0; wb_wen = 1'b1; wb_rd = 5'd7;
    #1 chk("fwd_wb", 32'(fwd_sel), 32'h0C);

    // WAW on x9, then the same instruction under a redirect.
    @(negedge clk); idle(); id_valid = 1'b1; id_rd = 5'd9; id_rd_wen = 1'b1; id_long = 1'b1;
    #1 chk("x9_issue", 32'(id_issue), 1);
    @(negedge clk); id_long = 1'b0;
    #1 chk("pend9_set", 32'(dut.pend[9]), 1);
    chk("waw_stall", 32'(stall), 1);
    chk("waw_noissue", 32'(id_issue), 0);
    @(negedge clk); pc_jump = 3'b010;
    #1 chk("redir_flush", 32'(flush), 1);
    chk("redir_nostall", 32'(stall), 0);
    chk("redir_noissue", 32'(id_issue), 0);
    @(negedge clk); idle();
    #1 chk("pend9_kept", 32'(dut.pend[9]), 1);
    chk("cnt_4", 32'(stall_cycles), 4);

    // Same-cycle set and clear on x3: set wins.
    @(negedge clk); id_valid = 1'b1; id_rd = 5'd3; id_rd_wen = 1'b1; id_long = 1'b1;
    wb_wen = 1'b1; wb_rd = 5'd3;
    #1 chk("x3_issue", 32'(id_issue), 1);
    @(negedge clk); idle(); id_valid = 1'b1; id_rs_used = 3'b111; exe_fwd_ok = 1'b1;
    #1 chk("pend3_setwins", 32'(dut.pend[3]), 1);
    chk("x0_nostall", 32'(stall), 0);
    chk("x0_fwd", 32'(fwd_sel), 0);
    chk("x0_issue", 32'(id_issue), 1);

    // Each source alone blocks on pending x9; unused sources read x3 and are ignored.
    for (int i = 0; i < int'(NSRC); i++) begin
      @(negedge clk); idle(); id_valid = 1'b1;
      rs_tmp = {5'd3, 5'd3, 5'd3};
      rs_tmp[i*RW +: RW] = 5'd9;
      id_rs = rs_tmp; id_rs_used = 3'(1 << i);
      #1 chk($sformatf("src%0d_block", i), 32'(stall), 1);
    end
    @(negedge clk); id_rs = {5'd9, 5'd9, 5'd9}; id_rs_used = 3'b000;
    #1 chk("unused_ignored", 32'(stall), 0);
    chk("unused_issue", 32'(id_issue), 1);
    @(negedge clk); idle();
    #1 chk("cnt_7", 32'(stall_cycles), 7);
    chk("err_low", 32'(hazard_err), 0);

    // Long stall: watchdog at 8 stalled cycles, counter saturates at F.
    id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd9}; id_rs_used = 3'b001;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); @(negedge clk); #1;
      if (j == 7) chk("err_before_to", 32'(hazard_err), 0);
      if (j == 8) begin
        chk("err_at_to", 32'(hazard_err), 1);
        chk("cnt_at_8", 32'(stall_cycles), 32'hF);
      end
      if (j == 20) begin
        chk("cnt_sat", 32'(stall_cycles), 32'hF);
        chk("long_stall", 32'(stall), 1);
      end
    end
    id_rs_used = 3'b000;
    @(negedge clk); #1 chk("err_sticky", 32'(hazard_err), 1);
    id_rs_used = 3'b001; pc_jump = PC_SEQ;
    #1 chk("restall", 32'(stall), 1);

    // Async reset mid-stall clears everything immediately.
    rst_n = 1'b0;
    #1 chk("arst_stall", 32'(stall), 0);
    chk("arst_issue", 32'(id_issue), 0);
    chk("arst_fwd", 32'(fwd_sel), 0);
    chk("arst_cnt", 32'(stall_cycles), 0);
    chk("arst_err", 32'(hazard_err), 0);
    chk("arst_pend9", 32'(dut.pend[9]), 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_nostall", 32'(stall), 0);
    chk("post_rst_issue", 32'(id_issue), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
